alu_issue_sched: RTL and testbench
==================================

# alu_issue_sched

Out-of-order issue scheduler for one integer/branch ALU port. Holds up to DEPTH renamed uops and wakes their source operands from writeback tag broadcasts. Each cycle it selects the oldest ready uop and issues it into a registered output stage that feeds the ALU input. Branch mispredicts squash younger entries; the issue stage supports a downstream stall.

## Interface
Parameters:
- DEPTH, 8: entry count, power of two, 2..16
- TAG_W, 7: physical tag width; tag MSB=1 means immediate/no dependency (always ready)
- SQN_W, 7: sequence-number width; age compare is signed(a-b)
- PAYLOAD_W, 128: opaque uop payload (opcode, fu, imm, pc, ...), passed through unchanged
- NUM_WB, 4: writeback broadcast ports

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous reset, active-low; one clock, synchronous reset, active-low, sampled on posedge clk
- IN_enqValid  in  1  enqueue request
- IN_enqSrcTagA / IN_enqSrcTagB  in  TAG_W  source tags
- IN_enqTagDst  in  TAG_W  destination tag
- IN_enqSqN  in  SQN_W  sequence number
- IN_enqPayload  in  PAYLOAD_W  uop payload
- OUT_enqReady  out  1  free entry available
- IN_wbValid  in  NUM_WB  writeback valid per port
- IN_wbTag  in  NUM_WB*TAG_W  writeback tags, port i at [i*TAG_W +: TAG_W]
- IN_branchTaken  in  1  mispredict flush
- IN_branchSqN  in  SQN_W  sqN of flushing branch
- IN_stall  in  1  ALU port blocked; hold issue stage
- IN_zcValid / IN_zcTag  in  1 / TAG_W  zero-cycle forward from ALU (used only with macro)
- OUT_issueValid  out  1  issue stage valid
- OUT_issueTagDst  out  TAG_W
- OUT_issueSqN  out  SQN_W
- OUT_issuePayload  out  PAYLOAD_W
- OUT_count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Entry fields: valid, srcTagA/B, rdyA/B, tagDst, sqN, payload.
- Enqueue: accepted when IN_enqValid && OUT_enqReady and the uop is not squashed. Written to the lowest-index free entry.
- Initial rdyX = tag MSB set, OR the tag matches a same-cycle IN_wbTag port with IN_wbValid.
- Wakeup: for each valid entry and each port i, IN_wbValid[i] && tag match sets rdyX at the next edge.
- Select: among valid entries with rdyA&&rdyB, pick the minimum sqN, where x is older than y iff signed(x-y)<0. sqNs are unique, so no tie rule is needed.
- Issue: if the stage is empty, or it is not stalled, the selected entry moves into the stage and its entry is freed at the same edge.
- While IN_stall=1 with a valid stage, the stage holds, no selection is consumed, and entries keep waking.
- Flush: IN_branchTaken squashes at the edge every item with signed(sqN-IN_branchSqN)>0. This covers queue entries, the issue stage (valid←0, even if stalled), and the enqueueing uop (dropped).
- Items with sqN equal to or older than IN_branchSqN survive.
- OUT_enqReady = (OUT_count<DEPTH), registered state only. An entry freed by issue or flush in cycle t becomes enqueue space at t+1.
- OUT_count tracks valid entries, excluding the issue stage.
- Reset (rst_n=0 at edge): all entries invalid, OUT_issueValid=0, OUT_count=0, OUT_enqReady=1 from the next cycle. Other outputs are don't-care while invalid.

## Timing
- Enqueue at edge t with both sources ready: selectable in cycle t+1; OUT_issueValid at t+1 edge+... i.e. visible in cycle t+2.
- Writeback tag broadcast in cycle t: dependent selectable in cycle t+1, issued visible in cycle t+2.
- Issue stage: one uop per cycle maximum, back-to-back when independent.
- Flush and enqueue in the same cycle: the flush compare applies to the enqueueing uop.
- Flush and issue in the same cycle: a squashed selected entry is not loaded; the stage becomes invalid.
- Wakeup and issue of different entries in the same cycle are independent.

## Configuration
- ALU_SCHED_SPEC_WAKEUP_EN defined:
  - IN_zcValid/IN_zcTag act as an extra wakeup source, visible in the same cycle's select. The select treats a matching source as ready combinationally, so a dependent of the uop in the issue stage issues in the very next cycle (back-to-back ALU chain).
  - The forward is ignored while IN_stall=1.
- ALU_SCHED_SPEC_WAKEUP_EN undefined:
  - zc ports are unused.
  - Dependent ALU ops issue only after the writeback broadcast, giving a minimum 2-cycle gap.

## Test plan
- Reset then enqueue sqN=5, tags A=0x40/B=0x41 (immediate MSB), dst=3 → OUT_issueValid in cycle t+2 with sqN=5, dst=3; OUT_count returns to 0.
- Enqueue sqN=10 (srcA=7 not ready), then sqN=11 (ready) → 11 issues first. Broadcast wb tag 7 → 10 issues two cycles later.
- Fill DEPTH=8 entries, none ready → OUT_enqReady=0 and a 9th enqueue is not accepted. One wakeup+issue → ready=1 one cycle after the entry frees.
- Entries sqN=20,21,22 plus 23 in the stalled issue stage; IN_branchTaken with sqN=21 → only 20, 21 remain, OUT_issueValid=0, OUT_count=2.
- With the macro: issue dst=9, then enqueued dependent src=9 → dependent issues the cycle after. Without the macro: it issues only after wb tag 9.
- sqN wrap: entries 0x7E and 0x01 both ready → 0x7E issues first.

Source files
------------

// File: rtl/alu_issue_sched.sv
// alu_issue_sched: out-of-order issue queue feeding one integer/branch ALU port.
// Latency: enqueue or wakeup at edge t -> selectable in cycle t+1 -> in the issue stage from edge t+2.
// Backpressure: OUT_enqReady comes from registered occupancy only; IN_stall holds the issue stage while entries keep waking.
//
// Ports: clk/rst_n (synchronous, active-low); IN_enq* enqueue a renamed uop (OUT_enqReady = free entry);
// IN_wbValid/IN_wbTag are NUM_WB writeback tag broadcasts; IN_branchTaken/IN_branchSqN squash younger uops;
// IN_stall holds the issue stage; OUT_issue* is the registered issue stage; OUT_count = occupied entries.
// Option: define ALU_SCHED_SPEC_WAKEUP_EN to use IN_zcValid/IN_zcTag as a same-cycle wakeup
// (back-to-back dependent ALU ops). Without it the zc ports are ignored.
module alu_issue_sched #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 7,
  parameter int SQN_W     = 7,
  parameter int PAYLOAD_W = 128,
  parameter int NUM_WB    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    IN_enqValid,
  input  logic [TAG_W-1:0]        IN_enqSrcTagA,
  input  logic [TAG_W-1:0]        IN_enqSrcTagB,
  input  logic [TAG_W-1:0]        IN_enqTagDst,
  input  logic [SQN_W-1:0]        IN_enqSqN,
  input  logic [PAYLOAD_W-1:0]    IN_enqPayload,
  output logic                    OUT_enqReady,
  input  logic [NUM_WB-1:0]       IN_wbValid,
  input  logic [NUM_WB*TAG_W-1:0] IN_wbTag,
  input  logic                    IN_branchTaken,
  input  logic [SQN_W-1:0]        IN_branchSqN,
  input  logic                    IN_stall,
  input  logic                    IN_zcValid,
  input  logic [TAG_W-1:0]        IN_zcTag,
  output logic                    OUT_issueValid,
  output logic [TAG_W-1:0]        OUT_issueTagDst,
  output logic [SQN_W-1:0]        OUT_issueSqN,
  output logic [PAYLOAD_W-1:0]    OUT_issuePayload,
  output logic [$clog2(DEPTH):0]  OUT_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0]     srcTagA;
    logic [TAG_W-1:0]     srcTagB;
    logic                 rdyA;
    logic                 rdyB;
    logic [TAG_W-1:0]     tagDst;
    logic [SQN_W-1:0]     sqN;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t           entries [DEPTH];
  logic [DEPTH-1:0] entryValid;

  logic                 stageValid;
  logic [TAG_W-1:0]     stageTagDst;
  logic [SQN_W-1:0]     stageSqN;
  logic [PAYLOAD_W-1:0] stagePayload;

  // Same-cycle forward from the ALU; trusted only while the stage is actually draining.
  logic             zcLive;
  logic [TAG_W-1:0] zcTagEff;
`ifdef ALU_SCHED_SPEC_WAKEUP_EN
  assign zcLive   = IN_zcValid && !IN_stall;
  assign zcTagEff = IN_zcTag;
`else
  logic unusedZc;
  assign zcLive   = 1'b0;
  assign zcTagEff = '0;
  assign unusedZc = ^{IN_zcValid, IN_zcTag};
`endif

  // a is younger than b when the wrapped difference is strictly positive.
  function automatic logic isYounger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] d;
    d = a - b;
    return (d != '0) && !d[SQN_W-1];
  endfunction

  // True when any broadcast source (writeback ports or the zc forward) produces this tag now.
  function automatic logic wakeHit(input logic [TAG_W-1:0] tag);
    logic hit;
    hit = zcLive && (tag == zcTagEff);
    for (int p = 0; p < NUM_WB; p++) begin
      if (IN_wbValid[p] && (IN_wbTag[p*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  logic [DEPTH-1:0] candidate;
  logic             selFound;
  logic [IDX_W-1:0] selIdx;
  logic [SQN_W-1:0] selSqN;
  logic [IDX_W-1:0] freeIdx;
  logic [CNT_W-1:0] occCount;

  always_comb begin
    candidate = '0;
    selFound  = 1'b0;
    selIdx    = '0;
    selSqN    = '0;
    freeIdx   = '0;
    occCount  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      candidate[i] = entryValid[i]
                   && (entries[i].rdyA || (zcLive && (entries[i].srcTagA == zcTagEff)))
                   && (entries[i].rdyB || (zcLive && (entries[i].srcTagB == zcTagEff)));
      // Oldest-first: sqNs are unique, so a running minimum is enough.
      if (candidate[i] && (!selFound || isYounger(selSqN, entries[i].sqN))) begin
        selFound = 1'b1;
        selIdx   = IDX_W'(i);
        selSqN   = entries[i].sqN;
      end
      occCount = occCount + CNT_W'(entryValid[i]);
    end
    // Scan downwards so the lowest free index wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!entryValid[i]) freeIdx = IDX_W'(i);
    end
  end

  logic canIssue;
  logic selSquash;
  logic enqSquash;
  logic enqFire;

  assign OUT_count    = occCount;
  assign OUT_enqReady = (occCount < CNT_W'(DEPTH));
  assign canIssue     = !stageValid || !IN_stall;
  assign selSquash    = IN_branchTaken && isYounger(selSqN, IN_branchSqN);
  assign enqSquash    = IN_branchTaken && isYounger(IN_enqSqN, IN_branchSqN);
  assign enqFire      = IN_enqValid && OUT_enqReady && !enqSquash;

  // Control state: entry valid bits and issue-stage valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entryValid <= '0;
      stageValid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (IN_branchTaken && isYounger(entries[i].sqN, IN_branchSqN)) entryValid[i] <= 1'b0;
      end
      // The selected entry leaves the queue even if the flush kills it on the way to the stage.
      if (canIssue && selFound) entryValid[selIdx] <= 1'b0;
      // freeIdx is never the selected or a flushed entry: it is currently invalid.
      if (enqFire) entryValid[freeIdx] <= 1'b1;

      if (canIssue) begin
        stageValid <= selFound && !selSquash;
      end else if (IN_branchTaken && isYounger(stageSqN, IN_branchSqN)) begin
        stageValid <= 1'b0;
      end
    end
  end

  // Datapath: entry contents, wakeup, and issue-stage payload (qualified by the valid bits).
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wakeHit(entries[i].srcTagA)) entries[i].rdyA <= 1'b1;
      if (wakeHit(entries[i].srcTagB)) entries[i].rdyB <= 1'b1;
    end
    // Placed after the wakeup loop so a new uop overrides stale ready bits of the free slot.
    if (enqFire) begin
      entries[freeIdx].srcTagA <= IN_enqSrcTagA;
      entries[freeIdx].srcTagB <= IN_enqSrcTagB;
      entries[freeIdx].rdyA    <= IN_enqSrcTagA[TAG_W-1] || wakeHit(IN_enqSrcTagA);
      entries[freeIdx].rdyB    <= IN_enqSrcTagB[TAG_W-1] || wakeHit(IN_enqSrcTagB);
      entries[freeIdx].tagDst  <= IN_enqTagDst;
      entries[freeIdx].sqN     <= IN_enqSqN;
      entries[freeIdx].payload <= IN_enqPayload;
    end
    if (canIssue && selFound) begin
      stageTagDst  <= entries[selIdx].tagDst;
      stageSqN     <= entries[selIdx].sqN;
      stagePayload <= entries[selIdx].payload;
    end
  end

  assign OUT_issueValid   = stageValid;
  assign OUT_issueTagDst  = stageTagDst;
  assign OUT_issueSqN     = stageSqN;
  assign OUT_issuePayload = stagePayload;

endmodule

// File: tb/tb_alu_issue_sched.sv
// tb_alu_issue_sched: directed bench for alu_issue_sched with a queue-based reference model.
// The model keeps the waiting uops as an unordered list and the issue stage as a record,
// compared against the DUT on every negedge, plus literal expectations at key cycles.
module tb_alu_issue_sched;
  localparam int DEPTH = 8;
  localparam int TAG_W = 7;
  localparam int SQN_W = 7;
  localparam int PW    = 128;
  localparam int NWB   = 4;
`ifdef ALU_SCHED_SPEC_WAKEUP_EN
  localparam bit ZC_ON = 1'b1;
`else
  localparam bit ZC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             enqValid;
  logic [TAG_W-1:0] enqA, enqB, enqDst;
  logic [SQN_W-1:0] enqSqN;
  logic [PW-1:0]    enqPl;
  logic             enqReady;
  logic [NWB-1:0]   wbValid;
  logic [NWB*TAG_W-1:0] wbTag;
  logic             brTaken;
  logic [SQN_W-1:0] brSqN;
  logic             stall;
  logic             zcValid;
  logic [TAG_W-1:0] zcTag;
  logic             issueValid;
  logic [TAG_W-1:0] issueTagDst;
  logic [SQN_W-1:0] issueSqN;
  logic [PW-1:0]    issuePayload;
  logic [3:0]       count;

  // The ALU forwards the result tag of whatever it is executing from the issue stage.
  assign zcValid = issueValid && !stall;
  assign zcTag   = issueTagDst;

  alu_issue_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W), .SQN_W(SQN_W), .PAYLOAD_W(PW), .NUM_WB(NWB)) dut (
    .clk(clk), .rst_n(rst_n),
    .IN_enqValid(enqValid), .IN_enqSrcTagA(enqA), .IN_enqSrcTagB(enqB), .IN_enqTagDst(enqDst),
    .IN_enqSqN(enqSqN), .IN_enqPayload(enqPl), .OUT_enqReady(enqReady),
    .IN_wbValid(wbValid), .IN_wbTag(wbTag),
    .IN_branchTaken(brTaken), .IN_branchSqN(brSqN), .IN_stall(stall),
    .IN_zcValid(zcValid), .IN_zcTag(zcTag),
    .OUT_issueValid(issueValid), .OUT_issueTagDst(issueTagDst), .OUT_issueSqN(issueSqN),
    .OUT_issuePayload(issuePayload), .OUT_count(count)
  );

  int nChecks = 0;
  int nPass   = 0;
  bit chk     = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [6:0]   a, b, dst, sqn;
    bit           ra, rb;
    logic [127:0] pl;
  } mEnt_t;

  mEnt_t        mq[$];
  bit           mStV;
  logic [6:0]   mStDst, mStSqN;
  logic [127:0] mStPl;

  function automatic bit younger(input logic [6:0] x, input logic [6:0] y);
    logic signed [6:0] d;
    d = x - y;
    return d > 0;
  endfunction

  function automatic bit tagKnown(input logic [6:0] t, input bit zcOn, input logic [6:0] zcT);
    if (t[6]) return 1'b1;
    for (int p = 0; p < NWB; p++)
      if (wbValid[p] && wbTag[p*TAG_W +: TAG_W] == t) return 1'b1;
    return zcOn && (t == zcT);
  endfunction

  function automatic logic [127:0] pl(input logic [6:0] s);
    return {16{~s[0], s}} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  endfunction

  always @(posedge clk) begin : model
    bit zcOn, canIss, enqOk, okA, okB;
    logic [6:0] zcT;
    int best;
    mEnt_t e;
    if (!rst_n) begin
      mq.delete();
      mStV = 1'b0;
    end else begin
      zcOn   = ZC_ON && mStV && !stall;
      zcT    = mStDst;
      enqOk  = enqValid && (mq.size() < DEPTH) && !(brTaken && younger(enqSqN, brSqN));
      canIss = !mStV || !stall;
      best   = -1;
      if (canIss) begin
        for (int k = 0; k < mq.size(); k++) begin
          okA = mq[k].ra || (zcOn && mq[k].a == zcT);
          okB = mq[k].rb || (zcOn && mq[k].b == zcT);
          if (okA && okB && (best < 0 || younger(mq[best].sqn, mq[k].sqn))) best = k;
        end
        mStV = 1'b0;
        if (best >= 0) begin
          if (!(brTaken && younger(mq[best].sqn, brSqN))) begin
            mStV   = 1'b1;
            mStDst = mq[best].dst;
            mStSqN = mq[best].sqn;
            mStPl  = mq[best].pl;
          end
          mq.delete(best);
        end
      end else if (brTaken && younger(mStSqN, brSqN)) begin
        mStV = 1'b0;
      end
      foreach (mq[k]) begin
        if (tagKnown(mq[k].a, zcOn, zcT)) mq[k].ra = 1'b1;
        if (tagKnown(mq[k].b, zcOn, zcT)) mq[k].rb = 1'b1;
      end
      for (int k = mq.size() - 1; k >= 0; k--)
        if (brTaken && younger(mq[k].sqn, brSqN)) mq.delete(k);
      if (enqOk) begin
        e.a = enqA; e.b = enqB; e.dst = enqDst; e.sqn = enqSqN; e.pl = enqPl;
        e.ra = tagKnown(enqA, zcOn, zcT);
        e.rb = tagKnown(enqB, zcOn, zcT);
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      check("issueValid", 128'(issueValid), 128'(mStV));
      if (mStV) begin
        check("issueTagDst", 128'(issueTagDst), 128'(mStDst));
        check("issueSqN", 128'(issueSqN), 128'(mStSqN));
        check("issuePayload", issuePayload, mStPl);
      end
      check("count", 128'(count), 128'(mq.size()));
      check("enqReady", 128'(enqReady), 128'(mq.size() < DEPTH));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enq(input logic [6:0] s, input logic [6:0] a, input logic [6:0] b, input logic [6:0] d);
    enqValid = 1'b1; enqSqN = s; enqA = a; enqB = b; enqDst = d; enqPl = pl(s);
    tick(1);
    enqValid = 1'b0;
  endtask

  task automatic wb(input logic [3:0] v, input logic [27:0] t);
    wbValid = v; wbTag = t;
    tick(1);
    wbValid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enqValid = 1'b0; enqA = '0; enqB = '0; enqDst = '0; enqSqN = '0; enqPl = '0;
    wbValid = '0; wbTag = '0; brTaken = 1'b0; brSqN = '0; stall = 1'b0;
    tick(2);
    check("rst_issueValid", 128'(issueValid), 128'd0);
    check("rst_count", 128'(count), 128'd0);
    check("rst_enqReady", 128'(enqReady), 128'd1);
    rst_n = 1'b1;
    chk   = 1'b1;

    // Immediate-source uop: stage valid two edges after enqueue.
    enq(7'd5, 7'h40, 7'h41, 7'd3);
    check("t1_count_queued", 128'(count), 128'd1);
    check("t1_not_yet", 128'(issueValid), 128'd0);
    tick(1);
    check("t1_valid", 128'(issueValid), 128'd1);
    check("t1_sqn", 128'(issueSqN), 128'd5);
    check("t1_dst", 128'(issueTagDst), 128'd3);
    check("t1_count_zero", 128'(count), 128'd0);
    tick(1);

    // Younger ready uop bypasses an older waiting one; wakeup then issues the older.
    enq(7'd10, 7'h07, 7'h41, 7'd20);
    enq(7'd11, 7'h40, 7'h41, 7'd21);
    tick(1);
    check("t2_first_sqn", 128'(issueSqN), 128'd11);
    wb(4'b0001, 28'h000_0007);
    check("t2_gap", 128'(issueValid), 128'd0);
    tick(1);
    check("t2_woken_valid", 128'(issueValid), 128'd1);
    check("t2_woken_sqn", 128'(issueSqN), 128'd10);
    tick(1);

    // Fill the queue with waiting uops, then free one slot.
    for (int k = 0; k < 8; k++) enq(7'(30 + k), 7'(16 + k), 7'h41, 7'(40 + k));
    check("t3_full_count", 128'(count), 128'd8);
    check("t3_full_ready", 128'(enqReady), 128'd0);
    enq(7'd38, 7'h40, 7'h41, 7'd48);
    check("t3_ninth_dropped", 128'(count), 128'd8);
    wb(4'b0001, 28'h000_0010);
    check("t3_ready_before_free", 128'(enqReady), 128'd0);
    tick(1);
    check("t3_ready_after_free", 128'(enqReady), 128'd1);
    check("t3_count_after_free", 128'(count), 128'd7);
    check("t3_issued_sqn", 128'(issueSqN), 128'd30);
    wb(4'b1111, {7'h14, 7'h13, 7'h12, 7'h11});
    wb(4'b0111, {7'h00, 7'h17, 7'h16, 7'h15});
    tick(8);
    check("t3_drained", 128'(count), 128'd0);

    // Flush with a stalled stage and a same-cycle younger enqueue.
    enq(7'd23, 7'h40, 7'h41, 7'd50);
    stall = 1'b1;
    enq(7'd20, 7'h40, 7'h41, 7'd51);
    enq(7'd21, 7'h22, 7'h41, 7'd52);
    enq(7'd22, 7'h23, 7'h41, 7'd53);
    check("t4_stalled_valid", 128'(issueValid), 128'd1);
    check("t4_stalled_sqn", 128'(issueSqN), 128'd23);
    check("t4_count_pre", 128'(count), 128'd3);
    brTaken = 1'b1; brSqN = 7'd21;
    enq(7'd24, 7'h40, 7'h41, 7'd54);
    brTaken = 1'b0;
    check("t4_stage_squashed", 128'(issueValid), 128'd0);
    check("t4_count_post", 128'(count), 128'd2);
    stall = 1'b0;
    tick(1);
    check("t4_survivor_sqn", 128'(issueSqN), 128'd20);
    wb(4'b0001, 28'h000_0022);
    tick(1);
    check("t4_second_sqn", 128'(issueSqN), 128'd21);
    tick(2);

    // Dependent of the uop in the issue stage.
    enq(7'd40, 7'h40, 7'h41, 7'd9);
    enq(7'd41, 7'h09, 7'h41, 7'd60);
    check("t5_producer_sqn", 128'(issueSqN), 128'd40);
    tick(1);
`ifdef ALU_SCHED_SPEC_WAKEUP_EN
    check("t5_b2b_valid", 128'(issueValid), 128'd1);
    check("t5_b2b_sqn", 128'(issueSqN), 128'd41);
`else
    check("t5_no_b2b", 128'(issueValid), 128'd0);
`endif
    wb(4'b0001, 28'h000_0009);
    check("t5_mid_gap", 128'(issueValid), 128'd0);
    tick(1);
`ifdef ALU_SCHED_SPEC_WAKEUP_EN
    check("t5_after_wb", 128'(issueValid), 128'd0);
`else
    check("t5_wb_valid", 128'(issueValid), 128'd1);
    check("t5_wb_sqn", 128'(issueSqN), 128'd41);
`endif
    tick(2);

    // Sequence-number wrap: 0x7E is older than 0x01.
    enq(7'h01, 7'h30, 7'h41, 7'd70);
    enq(7'h7E, 7'h30, 7'h41, 7'd71);
    wb(4'b0001, 28'h000_0030);
    tick(1);
    check("t6_wrap_first", 128'(issueSqN), 128'h7E);
    tick(1);
    check("t6_wrap_second", 128'(issueSqN), 128'h01);
    tick(2);
    check("end_count", 128'(count), 128'd0);

    chk = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
